id_ex_latch: RTL and testbench

ID_EX_LATCH -- requirements
Module: id_ex_latch

---
 rtl/id_ex_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 20 ++
 rtl/id_ex_latch.sv | 153 +++++++++++++++
 tb/tb_id_ex_latch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline latch: state encoding, control-field
// widths, control-bit positions and the writeback bypass selector.
package id_ex_pkg;

   localparam int unsigned RegW          = 5;  // register specifier width
   localparam int unsigned DataW         = 32;
   localparam int unsigned WbW           = 2;  // {regwrite, memtoreg}
   localparam int unsigned MW            = 3;  // {branch, memread, memwrite}
   localparam int unsigned ExW           = 4;  // {regdst, aluop[1:0], alusrc}
   localparam int unsigned WbRegWriteBit = 1;
   localparam int unsigned WbMemToRegBit = 0;
   localparam int unsigned MMemReadBit   = 1;

   typedef enum logic [1:0] {
      StEmpty  = 2'd0,
      StFull   = 2'd1,
      StBubble = 2'd2
   } state_e;

   // Pick the writeback value when it targets the source register; r0 never bypasses.
   function automatic logic [DataW-1:0] fwd_sel(input logic             wb_we,
                                                input logic [RegW-1:0]  wb_dst,
                                                input logic [DataW-1:0] wb_val,
                                                input logic [RegW-1:0]  src,
                                                input logic [DataW-1:0] rf_val);
      return (wb_we && (wb_dst != '0) && (wb_dst == src)) ? wb_val : rf_val;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register a
// held load is about to write.
module load_use_detect
   import id_ex_pkg::*;
(
   input  logic            i_held_memread,
   input  logic [RegW-1:0] i_held_rt,
   input  logic [RegW-1:0] i_in_rs,
   input  logic [RegW-1:0] i_in_rt,
   input  logic            i_in_valid,
   output logic            o_hazard
);

   // Register 0 is hard-wired, so a load targeting it can never create a dependency.
   always_comb begin
      o_hazard = i_held_memread && (i_held_rt != '0) && i_in_valid &&
                 ((i_held_rt == i_in_rs) || (i_held_rt == i_in_rt));
   end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline latch with valid/ready handshake, load-use bubble insertion and
// branch flush. Optional writeback bypass enabled by defining ID_EX_WB_FWD_EN.
module id_ex_latch
   import id_ex_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DataW-1:0] in_pc,
   input  logic [DataW-1:0] in_a,
   input  logic [DataW-1:0] in_b,
   input  logic [DataW-1:0] in_imm,
   input  logic [RegW-1:0]  in_rs,
   input  logic [RegW-1:0]  in_rt,
   input  logic [RegW-1:0]  in_rd,
   input  logic [WbW-1:0]   in_wb,
   input  logic [MW-1:0]    in_m,
   input  logic [ExW-1:0]   in_ex,
   input  logic             wb_regwrite,
   input  logic [RegW-1:0]  wb_rd,
   input  logic [DataW-1:0] wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DataW-1:0] out_pc,
   output logic [DataW-1:0] out_a,
   output logic [DataW-1:0] out_b,
   output logic [DataW-1:0] out_imm,
   output logic [RegW-1:0]  out_rs,
   output logic [RegW-1:0]  out_rt,
   output logic [RegW-1:0]  out_rd,
   output logic [WbW-1:0]   out_wb,
   output logic [MW-1:0]    out_m,
   output logic [ExW-1:0]   out_ex
);

   state_e           r_state;
   logic             r_valid;
   logic [DataW-1:0] r_pc, r_a, r_b, r_imm;
   logic [RegW-1:0]  r_rs, r_rt, r_rd;
   logic [WbW-1:0]   r_wb;
   logic [MW-1:0]    r_m;
   logic [ExW-1:0]   r_ex;

   logic             w_held_memread;
   logic             w_hazard;
   logic             w_ready;
   logic             w_capture;
   logic [DataW-1:0] w_a_next;
   logic [DataW-1:0] w_b_next;

   assign w_held_memread = r_valid && r_m[MMemReadBit];

   load_use_detect u_load_use_detect (
      .i_held_memread (w_held_memread),
      .i_held_rt      (r_rt),
      .i_in_rs        (in_rs),
      .i_in_rt        (in_rt),
      .i_in_valid     (in_valid),
      .o_hazard       (w_hazard)
   );

   // Capture implies a legal load in every state, so it needs no per-state qualification.
   assign w_ready   = (!r_valid || out_ready) && !w_hazard && !flush;
   assign w_capture = in_valid && w_ready;

`ifdef ID_EX_WB_FWD_EN
   assign w_a_next = fwd_sel(wb_regwrite, wb_rd, wb_data, in_rs, in_a);
   assign w_b_next = fwd_sel(wb_regwrite, wb_rd, wb_data, in_rt, in_b);
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_regwrite, wb_rd, wb_data};
   assign w_a_next    = in_a;
   assign w_b_next    = in_b;
`endif

   // Latch state machine: flush beats capture, capture beats drain/bubble, stall holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StEmpty;
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_imm   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
         r_wb    <= '0;
         r_m     <= '0;
         r_ex    <= '0;
      end else if (flush) begin
         r_state <= StEmpty;
         r_valid <= 1'b0;
         r_wb    <= '0;
         r_m     <= '0;
         r_ex    <= '0;
      end else if (w_capture) begin
         r_state <= StFull;
         r_valid <= 1'b1;
         r_pc    <= in_pc;
         r_a     <= w_a_next;
         r_b     <= w_b_next;
         r_imm   <= in_imm;
         r_rs    <= in_rs;
         r_rt    <= in_rt;
         r_rd    <= in_rd;
         r_wb    <= in_wb;
         r_m     <= in_m;
         r_ex    <= in_ex;
      end else begin
         unique case (r_state)
            StEmpty: begin
            end
            StFull: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  if (w_hazard) begin
                     // Bubble carries no side effects into execute.
                     r_state <= StBubble;
                     r_wb    <= '0;
                     r_m     <= '0;
                  end else begin
                     r_state <= StEmpty;
                  end
               end
            end
            StBubble: begin
               r_state <= StEmpty;
            end
            default: begin
               r_state <= StEmpty;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = w_ready;
   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign out_a     = r_a;
   assign out_b     = r_b;
   assign out_imm   = r_imm;
   assign out_rs    = r_rs;
   assign out_rt    = r_rt;
   assign out_rd    = r_rd;
   assign out_wb    = r_wb;
   assign out_m     = r_m;
   assign out_ex    = r_ex;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed scoreboard bench for id_ex_latch (build-aware for ID_EX_WB_FWD_EN).
module tb_id_ex_latch;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_a, in_b, in_imm;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [1:0]  in_wb;
   logic [2:0]  in_m;
   logic [3:0]  in_ex;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_a, out_b, out_imm;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic [1:0]  out_wb;
   logic [2:0]  out_m;
   logic [3:0]  out_ex;

   typedef struct packed {
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rs, rt, rd;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
   } item_t;

   item_t q[$];
   int    checks   = 0;
   int    failures = 0;
   logic  exp_rdy;

   id_ex_latch dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_wb(out_wb), .out_m(out_m), .out_ex(out_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected captured instruction derived from the current decode inputs.
   function automatic item_t model();
      item_t e;
      e.pc = in_pc; e.a = in_a; e.b = in_b; e.imm = in_imm;
      e.rs = in_rs; e.rt = in_rt; e.rd = in_rd;
      e.wb = in_wb; e.m = in_m; e.ex = in_ex;
`ifdef ID_EX_WB_FWD_EN
      if (wb_regwrite && wb_rd != 5'd0 && wb_rd == in_rs) e.a = wb_data;
      if (wb_regwrite && wb_rd != 5'd0 && wb_rd == in_rt) e.b = wb_data;
`endif
      return e;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
      in_valid = v; in_pc = pc; in_a = a; in_b = b; in_imm = pc ^ 32'h00ff_00ff;
      in_rs = rs; in_rt = rt; in_rd = rs + rt; in_wb = wb; in_m = m; in_ex = ex;
   endtask

   // One cycle: sample at negedge (ready check, pop, push), then advance past posedge.
   task automatic step();
      item_t e;
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid && out_ready) begin
         chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_a", out_a, e.a);
            chk("sb_b", out_b, e.b);
            chk("sb_imm", out_imm, e.imm);
            chk("sb_regs", {17'd0, out_rs, out_rt, out_rd}, {17'd0, e.rs, e.rt, e.rd});
            chk("sb_ctrl", {23'd0, out_wb, out_m, out_ex}, {23'd0, e.wb, e.m, e.ex});
         end
      end
      if (in_valid && exp_rdy) q.push_back(model());
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1; exp_rdy = 1'b1;
      wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_a | out_b | out_pc | out_imm, 32'd0);
      chk("rst_ctrl", {8'd0, out_rs, out_rt, out_rd, out_wb, out_m, out_ex}, 32'd0);
      rst = 1'b0;

      // Basic transfer, one-cycle latency.
      drive(1'b1, 32'h4, 32'd5, 32'd7, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1000);
      step();
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_a", out_a, 32'd5);
      chk("basic_b", out_b, 32'd7);
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back throughput.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 4 * i, 32'd100 + i, 32'd200 + i, 5'(i + 1), 5'(i + 9),
               2'b10, 3'b000, 4'(i));
         step();
         chk("b2b_valid", {31'd0, out_valid}, 32'd1);
         chk("b2b_a", out_a, 32'd100 + i);
      end
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Load-use hazard: one bubble, then the dependent add.
      drive(1'b1, 32'h200, 32'h10, 32'h11, 5'd1, 5'd3, 2'b11, 3'b010, 4'b0001);
      step();
      drive(1'b1, 32'h204, 32'h20, 32'h21, 5'd3, 5'd5, 2'b10, 3'b000, 4'b1100);
      exp_rdy = 1'b0;
      step();
      chk("bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("bubble_ctrl", {27'd0, out_wb, out_m}, 32'd0);
      exp_rdy = 1'b1;
      step();
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_pc", out_pc, 32'h204);
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Load to r0 followed by a reader of r0: no hazard.
      drive(1'b1, 32'h300, 32'h30, 32'h31, 5'd2, 5'd0, 2'b11, 3'b010, 4'b0001);
      step();
      drive(1'b1, 32'h304, 32'h40, 32'h41, 5'd0, 5'd0, 2'b10, 3'b000, 4'b1100);
      step();
      chk("r0_valid", {31'd0, out_valid}, 32'd1);
      chk("r0_pc", out_pc, 32'h304);
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Stall stability.
      drive(1'b1, 32'h400, 32'h1234, 32'h99, 5'd6, 5'd7, 2'b10, 3'b000, 4'b0010);
      step();
      out_ready = 1'b0;
      drive(1'b1, 32'h404, 32'h5555, 32'h66, 5'd8, 5'd9, 2'b10, 3'b000, 4'b0011);
      exp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_a", out_a, 32'h1234);
         chk("stall_pc", out_pc, 32'h400);
      end
      out_ready = 1'b1;
      exp_rdy = 1'b1;
      step();
      chk("unstall_a", out_a, 32'h5555);
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Flush while full with a new instruction presented.
      drive(1'b1, 32'h500, 32'h77, 32'h78, 5'd10, 5'd11, 2'b10, 3'b001, 4'b1111);
      step();
      drive(1'b1, 32'h504, 32'h88, 32'h89, 5'd12, 5'd13, 2'b11, 3'b000, 4'b0101);
      flush = 1'b1;
      exp_rdy = 1'b0;
      step();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ctrl", {23'd0, out_wb, out_m, out_ex}, 32'd0);
      flush = 1'b0;
      exp_rdy = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("flush_nocap", {31'd0, out_valid}, 32'd0);

      // Writeback bypass.
      wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'd99;
      drive(1'b1, 32'h600, 32'd11, 32'd22, 5'd4, 5'd4, 2'b10, 3'b000, 4'b0000);
      step();
`ifdef ID_EX_WB_FWD_EN
      chk("fwd_a", out_a, 32'd99);
      chk("fwd_b", out_b, 32'd99);
`else
      chk("nofwd_a", out_a, 32'd11);
      chk("nofwd_b", out_b, 32'd22);
`endif
      wb_rd = 5'd0;
      drive(1'b1, 32'h604, 32'd11, 32'd22, 5'd0, 5'd0, 2'b10, 3'b000, 4'b0000);
      step();
      chk("fwd_r0_a", out_a, 32'd11);
      wb_regwrite = 1'b0; wb_data = 32'd0;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Reset while holding an instruction discards it.
      drive(1'b1, 32'h700, 32'hAAAA, 32'hBBBB, 5'd14, 5'd15, 2'b11, 3'b010, 4'b1010);
      step();
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_a", out_a, 32'd0);
      chk("midrst_ctrl", {23'd0, out_wb, out_m, out_ex}, 32'd0);
      void'(q.pop_back());
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      chk("postrst_valid", {31'd0, out_valid}, 32'd0);

      chk("sb_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
